stage_id_hz: RTL and testbench

- Parametrised successor to the MIPS instruction-decode stage.
- Decodes the instruction, reads the register file and produces control signals, like the current stage.
- Adds four features the current stage lacks:
  - a valid bit
  - load-use hazard detection with stall
  - branch/jump flush into a bubble
  - write-before-read bypass in the register file
- Sits between the IF/ID register and the EX stage. The EX stage consumes all outputs as its ID/EX pipeline register.

---
 rtl/mips_pkg.sv | 78 +++++++
 rtl/regfile_bypass.sv | 59 +++++
 rtl/stage_id_hz.sv | 203 ++++++++++++++++++++
 tb/tb_stage_id_hz.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode vocabulary: opcode/funct codes, ALU and write-back
// encodings, and the ID/EX control word with its all-zero bubble value.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [3:0] {
        ALU_NOP = 4'd0,
        ALU_ADD = 4'd1,
        ALU_SUB = 4'd2,
        ALU_AND = 4'd3,
        ALU_OR  = 4'd4,
        ALU_XOR = 4'd5,
        ALU_NOR = 4'd6,
        ALU_SLT = 4'd7,
        ALU_SLL = 4'd8,
        ALU_SRL = 4'd9,
        ALU_LUI = 4'd10
    } alu_op_e;

    // WB_LINK writes PC+4 (jal); WB_MEM writes load data.
    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_MEM  = 2'd2,
        WB_LINK = 2'd3
    } wbi_e;

    // isJump marks any control transfer; isNotConditional separates j/jal/jr
    // from branches; isEq selects beq over bne.
    typedef struct packed {
        alu_op_e aluOp;
        logic    isJump;
        logic    isNotConditional;
        logic    isEq;
        logic    memWrite;
        logic    memRead;
        logic    aluSrc;
        logic    regDst;
        wbi_e    wbi;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{aluOp: ALU_NOP, isJump: 1'b0, isNotConditional: 1'b0,
                                      isEq: 1'b0, memWrite: 1'b0, memRead: 1'b0,
                                      aluSrc: 1'b0, regDst: 1'b0, wbi: WB_NONE};

    // Only these formats read rt as an operand; elsewhere rt is a destination or unused.
    function automatic logic rt_is_source(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_BNE) || (opcode == OP_SW);
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Register file with two combinational read ports, one write port, a hard-wired
// zero register and an optional write-to-read bypass for the same cycle.
module regfile_bypass #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 32,
    parameter int RF_BYPASS  = 1
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic [REG_ADDR_W-1:0] raddr1_i,
    input  logic [REG_ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0]     rdata1_o,
    output logic [DATA_W-1:0]     rdata2_o,
    input  logic                  we_i,
    input  logic [REG_ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0]     wdata_i
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic              wr_en;

    // Entry 0 is cleared by reset and never written, so it stays zero.
    assign wr_en = we_i && (waddr_i != '0) && (int'(waddr_i) < NUM_REGS);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic [REG_ADDR_W-1:0] ra;
            logic [DATA_W-1:0]     rd_val;

            assign ra = (gi == 0) ? raddr1_i : raddr2_i;

            always_comb begin
                rd_val = '0;
                if ((ra != '0) && (int'(ra) < NUM_REGS)) begin
                    if ((RF_BYPASS != 0) && wr_en && (waddr_i == ra)) begin
                        rd_val = wdata_i;
                    end else begin
                        rd_val = mem_q[ra];
                    end
                end
            end
        end
    endgenerate

    assign rdata1_o = g_rd[0].rd_val;
    assign rdata2_o = g_rd[1].rd_val;

endmodule

// File: rtl/stage_id_hz.sv
// MIPS instruction-decode stage with valid tracking, load-use stall, flush to
// bubble and a bypassed register file; outputs form the ID/EX register.
module stage_id_hz
    import mips_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 32,
    parameter int RF_BYPASS  = 1
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic [31:0]           instr_i,
    input  logic [DATA_W-1:0]     pc_id_i,
    input  logic                  valid_id_i,
    input  logic [DATA_W-1:0]     writeData_i,
    input  logic [REG_ADDR_W-1:0] writeAddr_i,
    input  logic                  regWrite_i,
    input  logic                  flush_i,
    input  logic                  ex_memRead_i,
    input  logic [REG_ADDR_W-1:0] ex_rt_i,
    output logic                  stall_o,
    output logic                  valid_ex_o,
    output logic [DATA_W-1:0]     pc_ex_o,
    output logic [3:0]            aluOp_o,
    output logic                  isJump_o,
    output logic                  isNotConditional_o,
    output logic                  isEq_o,
    output logic                  memWrite_o,
    output logic                  memRead_o,
    output logic                  aluSrc_o,
    output logic                  regDst_o,
    output logic [1:0]            wbi_o,
    output logic [DATA_W-1:0]     reg1_o,
    output logic [DATA_W-1:0]     reg2_o,
    output logic [DATA_W-1:0]     extendedInstr_o,
    output logic [REG_ADDR_W-1:0] regAddr1_o,
    output logic [REG_ADDR_W-1:0] regAddr2_o
);

    function automatic ctrl_t decode(input logic [31:0] ins);
        ctrl_t c;
        c = CTRL_BUBBLE;
        case (ins[31:26])
            OP_RTYPE: begin
                c.regDst = 1'b1;
                c.wbi    = WB_ALU;
                case (ins[5:0])
                    FN_ADD, FN_ADDU: c.aluOp = ALU_ADD;
                    FN_SUB, FN_SUBU: c.aluOp = ALU_SUB;
                    FN_AND:          c.aluOp = ALU_AND;
                    FN_OR:           c.aluOp = ALU_OR;
                    FN_XOR:          c.aluOp = ALU_XOR;
                    FN_NOR:          c.aluOp = ALU_NOR;
                    FN_SLT:          c.aluOp = ALU_SLT;
                    FN_SLL:          c.aluOp = ALU_SLL;
                    FN_SRL:          c.aluOp = ALU_SRL;
                    FN_JR: begin
                        c                  = CTRL_BUBBLE;
                        c.isJump           = 1'b1;
                        c.isNotConditional = 1'b1;
                    end
                    default:         c = CTRL_BUBBLE;
                endcase
            end
            OP_J: begin
                c.isJump           = 1'b1;
                c.isNotConditional = 1'b1;
            end
            OP_JAL: begin
                c.isJump           = 1'b1;
                c.isNotConditional = 1'b1;
                c.wbi              = WB_LINK;
            end
            OP_BEQ, OP_BNE: begin
                c.aluOp  = ALU_SUB;
                c.isJump = 1'b1;
                c.isEq   = (ins[31:26] == OP_BEQ);
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                c.aluSrc = 1'b1;
                c.wbi    = WB_ALU;
                case (ins[31:26])
                    OP_SLTI: c.aluOp = ALU_SLT;
                    OP_ANDI: c.aluOp = ALU_AND;
                    OP_ORI:  c.aluOp = ALU_OR;
                    OP_XORI: c.aluOp = ALU_XOR;
                    OP_LUI:  c.aluOp = ALU_LUI;
                    default: c.aluOp = ALU_ADD;
                endcase
            end
            OP_LW: begin
                c.aluOp   = ALU_ADD;
                c.aluSrc  = 1'b1;
                c.memRead = 1'b1;
                c.wbi     = WB_MEM;
            end
            OP_SW: begin
                c.aluOp    = ALU_ADD;
                c.aluSrc   = 1'b1;
                c.memWrite = 1'b1;
            end
            default: c = CTRL_BUBBLE;
        endcase
        return c;
    endfunction

    logic [5:0]            opcode;
    logic [REG_ADDR_W-1:0] rs, rt;
    logic [DATA_W-1:0]     rs_val, rt_val, imm_ext;

    assign opcode  = instr_i[31:26];
    assign rs      = REG_ADDR_W'(instr_i[25:21]);
    assign rt      = REG_ADDR_W'(instr_i[20:16]);
    assign imm_ext = {{(DATA_W-16){instr_i[15]}}, instr_i[15:0]};

    regfile_bypass #(
        .DATA_W    (DATA_W),
        .REG_ADDR_W(REG_ADDR_W),
        .NUM_REGS  (NUM_REGS),
        .RF_BYPASS (RF_BYPASS)
    ) u_rf (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .raddr1_i(rs),
        .raddr2_i(rt),
        .rdata1_o(rs_val),
        .rdata2_o(rt_val),
        .we_i    (regWrite_i),
        .waddr_i (writeAddr_i),
        .wdata_i (writeData_i)
    );

    assign stall_o = valid_id_i && ex_memRead_i && (ex_rt_i != '0) &&
                     ((ex_rt_i == rs) || ((ex_rt_i == rt) && rt_is_source(opcode)));

    ctrl_t                 ctrl_q, ctrl_d;
    logic                  valid_q, valid_d;
    logic [DATA_W-1:0]     pc_q, pc_d, reg1_q, reg1_d, reg2_q, reg2_d, ext_q, ext_d;
    logic [REG_ADDR_W-1:0] ra1_q, ra1_d, ra2_q, ra2_d;

    // Flush, stall and an invalid slot all collapse to the same zeroed bubble.
    always_comb begin
        ctrl_d  = CTRL_BUBBLE;
        valid_d = 1'b0;
        pc_d    = '0;
        reg1_d  = '0;
        reg2_d  = '0;
        ext_d   = '0;
        ra1_d   = '0;
        ra2_d   = '0;
        if (valid_id_i && !flush_i && !stall_o) begin
            ctrl_d  = decode(instr_i);
            valid_d = 1'b1;
            pc_d    = pc_id_i;
            reg1_d  = rs_val;
            reg2_d  = rt_val;
            ext_d   = imm_ext;
            ra1_d   = rs;
            ra2_d   = rt;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            ctrl_q  <= CTRL_BUBBLE;
            valid_q <= 1'b0;
            pc_q    <= '0;
            reg1_q  <= '0;
            reg2_q  <= '0;
            ext_q   <= '0;
            ra1_q   <= '0;
            ra2_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            reg1_q  <= reg1_d;
            reg2_q  <= reg2_d;
            ext_q   <= ext_d;
            ra1_q   <= ra1_d;
            ra2_q   <= ra2_d;
        end
    end

    assign valid_ex_o         = valid_q;
    assign pc_ex_o            = pc_q;
    assign aluOp_o            = ctrl_q.aluOp;
    assign isJump_o           = ctrl_q.isJump;
    assign isNotConditional_o = ctrl_q.isNotConditional;
    assign isEq_o             = ctrl_q.isEq;
    assign memWrite_o         = ctrl_q.memWrite;
    assign memRead_o          = ctrl_q.memRead;
    assign aluSrc_o           = ctrl_q.aluSrc;
    assign regDst_o           = ctrl_q.regDst;
    assign wbi_o              = ctrl_q.wbi;
    assign reg1_o             = reg1_q;
    assign reg2_o             = reg2_q;
    assign extendedInstr_o    = ext_q;
    assign regAddr1_o         = ra1_q;
    assign regAddr2_o         = ra2_q;

endmodule

// File: tb/tb_stage_id_hz.sv
// Directed, table-driven bench for stage_id_hz; runs a bypassing and a
// non-bypassing instance side by side on identical stimulus.
module tb_stage_id_hz;

    // Control word as {aluOp[3:0], isJump, isNotCond, isEq, memWrite, memRead, aluSrc, regDst, wbi[1:0]}
    localparam logic [12:0] C_NONE = 13'd0;
    localparam logic [12:0] C_ADD  = {4'd1, 7'b0000001, 2'd1};
    localparam logic [12:0] C_OR   = {4'd4, 7'b0000001, 2'd1};
    localparam logic [12:0] C_LW   = {4'd1, 7'b0000110, 2'd2};
    localparam logic [12:0] C_SW   = {4'd1, 7'b0001010, 2'd0};
    localparam logic [12:0] C_BEQ  = {4'd2, 7'b1010000, 2'd0};
    localparam logic [12:0] C_J    = {4'd0, 7'b1100000, 2'd0};
    localparam logic [12:0] C_ADDI = {4'd1, 7'b0000010, 2'd1};

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        flush;
        logic        mr;
        logic [4:0]  exrt;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        e_stall;
        logic        e_valid;
        logic [12:0] e_ctl;
        logic [31:0] e_r1, e_r1nb, e_r2, e_r2nb;
        logic [4:0]  e_ra1, e_ra2;
        logic [31:0] e_ext, e_pc;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, valid_id, regWrite, flush, ex_memRead;
    logic [31:0] instr, pc_id, writeData;
    logic [4:0]  writeAddr, ex_rt;

    logic        b_stall, b_valid, b_jmp, b_nc, b_eq, b_mw, b_mr, b_src, b_rd;
    logic [3:0]  b_alu;
    logic [1:0]  b_wbi;
    logic [31:0] b_pc, b_r1, b_r2, b_ext;
    logic [4:0]  b_ra1, b_ra2;
    logic        n_stall, n_valid, n_jmp, n_nc, n_eq, n_mw, n_mr, n_src, n_rd;
    logic [3:0]  n_alu;
    logic [1:0]  n_wbi;
    logic [31:0] n_pc, n_r1, n_r2, n_ext;
    logic [4:0]  n_ra1, n_ra2;
    logic [12:0] b_ctl, n_ctl;

    assign b_ctl = {b_alu, b_jmp, b_nc, b_eq, b_mw, b_mr, b_src, b_rd, b_wbi};
    assign n_ctl = {n_alu, n_jmp, n_nc, n_eq, n_mw, n_mr, n_src, n_rd, n_wbi};

    stage_id_hz #(.DATA_W(32), .REG_ADDR_W(5), .NUM_REGS(32), .RF_BYPASS(1)) dut_b (
        .clock_i(clk), .reset_i(reset), .instr_i(instr), .pc_id_i(pc_id), .valid_id_i(valid_id),
        .writeData_i(writeData), .writeAddr_i(writeAddr), .regWrite_i(regWrite), .flush_i(flush),
        .ex_memRead_i(ex_memRead), .ex_rt_i(ex_rt), .stall_o(b_stall), .valid_ex_o(b_valid),
        .pc_ex_o(b_pc), .aluOp_o(b_alu), .isJump_o(b_jmp), .isNotConditional_o(b_nc), .isEq_o(b_eq),
        .memWrite_o(b_mw), .memRead_o(b_mr), .aluSrc_o(b_src), .regDst_o(b_rd), .wbi_o(b_wbi),
        .reg1_o(b_r1), .reg2_o(b_r2), .extendedInstr_o(b_ext), .regAddr1_o(b_ra1), .regAddr2_o(b_ra2)
    );

    stage_id_hz #(.DATA_W(32), .REG_ADDR_W(5), .NUM_REGS(32), .RF_BYPASS(0)) dut_nb (
        .clock_i(clk), .reset_i(reset), .instr_i(instr), .pc_id_i(pc_id), .valid_id_i(valid_id),
        .writeData_i(writeData), .writeAddr_i(writeAddr), .regWrite_i(regWrite), .flush_i(flush),
        .ex_memRead_i(ex_memRead), .ex_rt_i(ex_rt), .stall_o(n_stall), .valid_ex_o(n_valid),
        .pc_ex_o(n_pc), .aluOp_o(n_alu), .isJump_o(n_jmp), .isNotConditional_o(n_nc), .isEq_o(n_eq),
        .memWrite_o(n_mw), .memRead_o(n_mr), .aluSrc_o(n_src), .regDst_o(n_rd), .wbi_o(n_wbi),
        .reg1_o(n_r1), .reg2_o(n_r2), .extendedInstr_o(n_ext), .regAddr1_o(n_ra1), .regAddr2_o(n_ra2)
    );

    int checks = 0;
    int errors = 0;
    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    // Row that issues: valid_ex=1 and pc_ex follows pc_id.
    function automatic vec_t row(input logic [31:0] ins, input int pc, input int v, input int f, input int mr,
                                 input int exrt, input int we, input int wa, input logic [31:0] wd,
                                 input logic [12:0] ctl, input logic [31:0] r1, input logic [31:0] r1nb,
                                 input logic [31:0] r2, input logic [31:0] r2nb, input int ra1, input int ra2,
                                 input logic [31:0] ext);
        vec_t r;
        r.instr = ins; r.pc = 32'(pc); r.valid = 1'(v); r.flush = 1'(f); r.mr = 1'(mr); r.exrt = 5'(exrt);
        r.we = 1'(we); r.wa = 5'(wa); r.wd = wd; r.e_stall = 1'b0; r.e_valid = 1'b1; r.e_ctl = ctl;
        r.e_r1 = r1; r.e_r1nb = r1nb; r.e_r2 = r2; r.e_r2nb = r2nb; r.e_ra1 = 5'(ra1); r.e_ra2 = 5'(ra2);
        r.e_ext = ext; r.e_pc = 32'(pc);
        return r;
    endfunction

    // Row that must register the all-zero bubble.
    function automatic vec_t bub(input logic [31:0] ins, input int pc, input int v, input int f, input int mr,
                                 input int exrt, input int st);
        vec_t r;
        r = row(ins, pc, v, f, mr, exrt, 0, 0, 32'h0, C_NONE, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0);
        r.e_stall = 1'(st);
        r.e_valid = 1'b0;
        r.e_pc    = 32'h0;
        return r;
    endfunction

    task automatic drive(input vec_t v);
        instr = v.instr; pc_id = v.pc; valid_id = v.valid; flush = v.flush;
        ex_memRead = v.mr; ex_rt = v.exrt; regWrite = v.we; writeAddr = v.wa; writeData = v.wd;
    endtask

    task automatic check_regs(input string tag, input vec_t v);
        chk({tag, ".valid_ex"}, 32'(b_valid), 32'(v.e_valid));
        chk({tag, ".ctl"}, 32'(b_ctl), 32'(v.e_ctl));
        chk({tag, ".pc_ex"}, b_pc, v.e_pc);
        chk({tag, ".reg1"}, b_r1, v.e_r1);
        chk({tag, ".reg2"}, b_r2, v.e_r2);
        chk({tag, ".regAddr1"}, 32'(b_ra1), 32'(v.e_ra1));
        chk({tag, ".regAddr2"}, 32'(b_ra2), 32'(v.e_ra2));
        chk({tag, ".ext"}, b_ext, v.e_ext);
        chk({tag, ".nb.valid_ex"}, 32'(n_valid), 32'(v.e_valid));
        chk({tag, ".nb.ctl"}, 32'(n_ctl), 32'(v.e_ctl));
        chk({tag, ".nb.reg1"}, n_r1, v.e_r1nb);
        chk({tag, ".nb.reg2"}, n_r2, v.e_r2nb);
    endtask

    task automatic apply(input string tag, input vec_t v);
        drive(v);
        #1;
        chk({tag, ".stall"}, 32'(b_stall), 32'(v.e_stall));
        chk({tag, ".nb.stall"}, 32'(n_stall), 32'(v.e_stall));
        @(posedge clk);
        #1;
        check_regs(tag, v);
        $display("%s instr=%h stall=%b valid_ex=%b ctl=%h reg1=%h/%h reg2=%h/%h",
                 tag, v.instr, v.e_stall, b_valid, b_ctl, b_r1, n_r1, b_r2, n_r2);
    endtask

    initial begin
        vec_t zero_v;

        // Reset with everything quiet; all registered outputs must be zero.
        reset = 1'b1;
        drive(bub(32'h0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        @(posedge clk);
        #1;
        zero_v = bub(32'h0, 0, 0, 0, 0, 0, 0);
        check_regs("reset", zero_v);
        $display("reset valid_ex=%b ctl=%h pc_ex=%h", b_valid, b_ctl, b_pc);
        reset = 1'b0;

        //            instr                         pc      v f mr rt we wa wd            ctl     r1            r1nb          r2          r2nb        ra1 ra2 ext
        vq.push_back(row(rtype(1, 2, 3, 6'h20),      'h100, 1,0,0, 0, 0, 0, 32'h0,        C_ADD,  32'h0,        32'h0,        32'h0,      32'h0,      1, 2, 32'h00001820));
        vq.push_back(row(rtype(5, 0, 6, 6'h25),      'h104, 1,0,0, 0, 1, 5, 32'hDEADBEEF, C_OR,   32'hDEADBEEF, 32'h0,        32'h0,      32'h0,      5, 0, 32'h00003025));
        vq.push_back(row(rtype(5, 0, 6, 6'h25),      'h108, 1,0,0, 0, 0, 0, 32'h0,        C_OR,   32'hDEADBEEF, 32'hDEADBEEF, 32'h0,      32'h0,      5, 0, 32'h00003025));
        vq.push_back(bub(rtype(4, 1, 7, 6'h20),      'h10C, 1,0,1, 4, 1));
        vq.push_back(row(rtype(4, 1, 7, 6'h20),      'h10C, 1,0,0, 4, 0, 0, 32'h0,        C_ADD,  32'h0,        32'h0,        32'h0,      32'h0,      4, 1, 32'h00003820));
        vq.push_back(row(itype(6'h23, 9, 4, 16'h0),  'h110, 1,0,1, 4, 0, 0, 32'h0,        C_LW,   32'h0,        32'h0,        32'h0,      32'h0,      9, 4, 32'h00000000));
        vq.push_back(bub(itype(6'h2B, 2, 4, 16'hFFFC), 'h114, 1,0,1, 4, 1));
        vq.push_back(row(itype(6'h2B, 2, 4, 16'hFFFC), 'h114, 1,0,0, 4, 0, 0, 32'h0,      C_SW,   32'h0,        32'h0,        32'h0,      32'h0,      2, 4, 32'hFFFFFFFC));
        vq.push_back(bub(rtype(4, 1, 7, 6'h20),      'h118, 1,1,1, 4, 1));
        vq.push_back(row(rtype(0, 1, 7, 6'h20),      'h11C, 1,0,1, 0, 0, 0, 32'h0,        C_ADD,  32'h0,        32'h0,        32'h0,      32'h0,      0, 1, 32'h00003820));
        vq.push_back(bub(rtype(4, 1, 7, 6'h20),      'h120, 0,0,1, 4, 0));
        vq.push_back(row(itype(6'h04, 1, 2, 16'h10), 'h124, 1,0,0, 0, 0, 0, 32'h0,        C_BEQ,  32'h0,        32'h0,        32'h0,      32'h0,      1, 2, 32'h00000010));
        vq.push_back(row(32'h08040000,               'h128, 1,0,1, 4, 0, 0, 32'h0,        C_J,    32'h0,        32'h0,        32'h0,      32'h0,      0, 4, 32'h00000000));
        vq.push_back(row(itype(6'h08, 9, 4, 16'h5),  'h12C, 1,0,1, 4, 0, 0, 32'h0,        C_ADDI, 32'h0,        32'h0,        32'h0,      32'h0,      9, 4, 32'h00000005));
        vq.push_back(row(32'hFC000000,               'h130, 1,0,0, 0, 0, 0, 32'h0,        C_NONE, 32'h0,        32'h0,        32'h0,      32'h0,      0, 0, 32'h00000000));
        vq.push_back(row(rtype(0, 0, 6, 6'h25),      'h134, 1,0,0, 0, 1, 0, 32'h0000FFFF, C_OR,   32'h0,        32'h0,        32'h0,      32'h0,      0, 0, 32'h00003025));
        vq.push_back(row(rtype(0, 0, 6, 6'h25),      'h138, 1,0,0, 0, 0, 0, 32'h0,        C_OR,   32'h0,        32'h0,        32'h0,      32'h0,      0, 0, 32'h00003025));
        vq.push_back(row(rtype(9, 9, 3, 6'h20),      'h13C, 1,0,0, 0, 1, 8, 32'h00000055, C_ADD,  32'h0,        32'h0,        32'h0,      32'h0,      9, 9, 32'h00001820));
        vq.push_back(row(rtype(8, 8, 3, 6'h20),      'h140, 1,0,0, 0, 0, 0, 32'h0,        C_ADD,  32'h55,       32'h55,       32'h55,     32'h55,     8, 8, 32'h00001820));
        vq.push_back(row(rtype(1, 10, 3, 6'h20),     'h144, 1,0,0, 0, 1, 10, 32'h00001234, C_ADD, 32'h0,        32'h0,        32'h1234,   32'h0,      1, 10, 32'h00001820));

        foreach (vq[k]) begin
            apply($sformatf("v%0d", k), vq[k]);
        end

        // Mid-stream reset: overrides decode and a pending write to $8.
        drive(row(rtype(8, 8, 3, 6'h20), 'h200, 1, 0, 0, 0, 1, 8, 32'h00000077,
                  C_ADD, 32'h0, 32'h0, 32'h0, 32'h0, 8, 8, 32'h00001820));
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_regs("midreset", zero_v);
        $display("midreset valid_ex=%b ctl=%h pc_ex=%h reg1=%h", b_valid, b_ctl, b_pc, b_r1);
        reset = 1'b0;

        // $8 held 0x55 before reset; it must now read back zero.
        apply("after_reset", row(rtype(8, 8, 3, 6'h20), 'h204, 1, 0, 0, 0, 0, 0, 32'h0,
                                 C_ADD, 32'h0, 32'h0, 32'h0, 32'h0, 8, 8, 32'h00001820));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
